// File: rtl/ts_ram_rd_arbiter.sv
// Round-robin read arbiter for TS buffer RAM port B: requester A (DMA readback) vs B (TS output).
// Latency: grant/address combinational in cycle t; tagged rd_data with a/b_dvld in cycle t+RD_LAT+1.
// Backpressure: a requester not granted must hold req/addr; the owner yields after BURST_MAX if the other waits.
module ts_ram_rd_arbiter #(
    parameter int ADDR_W    = 11,
    parameter int DATA_W    = 512,
    parameter int RD_LAT    = 1,
    parameter int BURST_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_req,
    input  logic [ADDR_W-1:0] a_addr,
    output logic              a_gnt,
    output logic              a_dvld,
    input  logic              b_req,
    input  logic [ADDR_W-1:0] b_addr,
    output logic              b_gnt,
    output logic              b_dvld,
    output logic              ram_en,
    output logic [ADDR_W-1:0] ram_raddr,
    input  logic [DATA_W-1:0] ram_doutb,
    output logic [DATA_W-1:0] rd_data,
    output logic [15:0]       grant_cnt_a,
    output logic [15:0]       grant_cnt_b
);

    typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;

    localparam logic [3:0] BMAX = 4'(BURST_MAX);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        rr_q, rr_d;          // last owner: 1 = B, 0 = A
    logic [3:0]  cnt_inc;
    logic        gnt_a, gnt_b;
    logic [1:0]  tag_q [RD_LAT];
    logic        a_dvld_q, b_dvld_q;
    logic [DATA_W-1:0] rd_data_q;
    logic [15:0] gcnt_a_q, gcnt_b_q;

    assign cnt_inc = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rr_d    = rr_q;
        gnt_a   = 1'b0;
        gnt_b   = 1'b0;
        case (state_q)
            IDLE: begin
                if (a_req && (!b_req || rr_q)) begin
                    gnt_a   = 1'b1;
                    state_d = OWN_A;
                    cnt_d   = 4'd1;
                end else if (b_req) begin
                    gnt_b   = 1'b1;
                    state_d = OWN_B;
                    cnt_d   = 4'd1;
                end
            end
            OWN_A: begin
                if (a_req && (!b_req || cnt_q < BMAX)) begin
                    gnt_a = 1'b1;
                    cnt_d = cnt_inc;
                end else if (b_req) begin
                    gnt_b   = 1'b1;
                    state_d = OWN_B;
                    cnt_d   = 4'd1;
                    rr_d    = 1'b0;
                end else begin
                    state_d = IDLE;
                    rr_d    = 1'b0;
                end
            end
            OWN_B: begin
                if (b_req && (!a_req || cnt_q < BMAX)) begin
                    gnt_b = 1'b1;
                    cnt_d = cnt_inc;
                end else if (a_req) begin
                    gnt_a   = 1'b1;
                    state_d = OWN_A;
                    cnt_d   = 4'd1;
                    rr_d    = 1'b1;
                end else begin
                    state_d = IDLE;
                    rr_d    = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // Reset masks grants so nothing reaches the RAM or the tag pipe.
        if (rst) begin
            gnt_a = 1'b0;
            gnt_b = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            rr_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rr_q    <= rr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RD_LAT; i++) tag_q[i] <= 2'b00;
            a_dvld_q  <= 1'b0;
            b_dvld_q  <= 1'b0;
            rd_data_q <= '0;
            gcnt_a_q  <= 16'd0;
            gcnt_b_q  <= 16'd0;
        end else begin
            tag_q[0] <= {gnt_a, gnt_b};
            for (int i = 1; i < RD_LAT; i++) tag_q[i] <= tag_q[i-1];
            a_dvld_q  <= tag_q[RD_LAT-1][1];
            b_dvld_q  <= tag_q[RD_LAT-1][0];
            rd_data_q <= ram_doutb;
            if (gnt_a && gcnt_a_q != 16'hFFFF) gcnt_a_q <= gcnt_a_q + 16'd1;
            if (gnt_b && gcnt_b_q != 16'hFFFF) gcnt_b_q <= gcnt_b_q + 16'd1;
        end
    end

    assign a_gnt       = gnt_a;
    assign b_gnt       = gnt_b;
    assign ram_en      = gnt_a | gnt_b;
    assign ram_raddr   = gnt_a ? a_addr : (gnt_b ? b_addr : '0);
    assign a_dvld      = a_dvld_q;
    assign b_dvld      = b_dvld_q;
    assign rd_data     = rd_data_q;
    assign grant_cnt_a = gcnt_a_q;
    assign grant_cnt_b = gcnt_b_q;

endmodule
